seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Sequential unsigned restoring divider. It is the inverse operation of the team's combinational MULT block: it recovers the quotient and remainder from a dividend and divisor. It uses a start/done handshake and produces one quotient bit per clock. It sits beside MULT in the arithmetic lab set, and its results are cross-checked with MULT as quotient*divisor + remainder == dividend.

Parameters:
WIDTH, 4, bit width of dividend, divisor, quotient and remainder (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request pulse; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; sampled with start
divisor  input  WIDTH  unsigned divisor; sampled with start
quotient  output  WIDTH  registered quotient; valid from done until next accepted start
remainder  output  WIDTH  registered remainder; same validity as quotient
busy  output  1  high while a division is in progress (CALC state)
done  output  1  one-cycle pulse when results become valid
div_by_zero  output  1  registered flag; high with done when divisor was 0, held until next accepted start

Behaviour:
- Reset on a rst-high clock edge: state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; iteration counter=0. rst has priority over all other inputs, including mid-division; any partial result is discarded.
- States: IDLE, CALC, DONE.
- IDLE, start=1, divisor!=0 (call this edge 0):
  - latch divisor into a WIDTH-bit register; load the working quotient shift register with dividend
  - working remainder (WIDTH+1 bits) = 0; counter = WIDTH
  - div_by_zero=0; next state CALC; busy=1 from edge 0
- IDLE, start=1, divisor==0:
  - quotient = all ones; remainder = dividend; div_by_zero=1; done=1 at edge 0
  - next state DONE; busy stays 0
- IDLE, start=0: hold all outputs; done=0.
- CALC, one iteration per edge (edges 1..WIDTH):
  - shift {rem, q} left by one, bringing the q MSB into the rem LSB
  - if shifted rem >= divisor, then rem -= divisor and q LSB = 1; else q LSB = 0
  - counter decrements
  - on the edge where counter goes 1->0: write quotient/remainder outputs, done=1, busy=0, next state DONE
- DONE: lasts one cycle; done returns to 0 at the next edge; next state IDLE. start is ignored in DONE, and its operands are not latched.
- Latency: done is high in the cycle after edge WIDTH (WIDTH clocks after the start sample); a new start is accepted no earlier than edge WIDTH+2. Divide-by-zero latency is 1 clock.
- start while busy or in DONE: ignored, and no operand change affects the in-flight result.
- quotient/remainder/div_by_zero outputs change only at a done edge or at reset; they hold between operations.
- Arithmetic: the working remainder is WIDTH+1 bits so the compare never overflows. Results satisfy quotient*divisor+remainder==dividend and remainder<divisor.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start pulse -> busy high 4 cycles, done pulse 4 clocks after start; quotient=4, remainder=1, div_by_zero=0.
- Boundaries: 15/1 -> q=15 r=0; 5/7 -> q=0 r=5; 0/5 -> q=0 r=0; 15/15 -> q=1 r=0; each with done after exactly 4 clocks.
- 9/0 -> done one clock after start, busy never high, quotient=15, remainder=9, div_by_zero=1. A following 8/2 -> div_by_zero clears, q=4 r=0.
- Start 14/4, then re-pulse start with 3/1 on cycles 2 and 4 -> ignored; result q=3 r=2 and exactly one done pulse.
- Start 12/5, assert rst at cycle 2 -> next edge all outputs 0 and state IDLE, no done pulse; next start 12/5 completes with q=2 r=2.
- Exhaustive sweep of all 256 operand pairs (divisor 0 included), back-to-back starts at minimum spacing. Check q and r against / and %, and check q*d+r==a using MULT-equivalent multiplication for the 2-bit subset; check div_by_zero only on divisor 0.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero completes in one clock with quotient all ones and remainder = dividend.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    // One restoring step: shift {rem, q} left, subtract divisor when it fits.
    always_comb begin
        rem_shift = (rem_q << 1) | (WIDTH + 1)'(q_q[WIDTH-1]);
        rem_d     = rem_shift;
        q_d       = {q_q[WIDTH-2:0], 1'b0};
        if (rem_shift >= {1'b0, dvs_q}) begin
            rem_d = rem_shift - {1'b0, dvs_q};
            q_d   = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            dvs_q       <= divisor;
                            q_q         <= dividend;
                            rem_q       <= '0;
                            cnt_q       <= CW'(WIDTH);
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state_q     <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quotient  <= q_d;
                        remainder <= rem_d[WIDTH-1:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases with literal expectations, exhaustive sweep,
// and random traffic, all cross-checked every cycle against a timing/arithmetic model.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edge index, when the divider is free, when done fires, which cycles are busy.
    int           ec = 0;
    int           ready = 0;
    int           done_at = -10;
    int           busy_lo = -10;
    int           busy_hi = -10;
    bit           model_en = 1'b0;
    logic [W-1:0] pq, pr, exp_q, exp_r;
    logic         pz, exp_z, exp_busy, exp_done;

    initial begin
        pq = '0; pr = '0; pz = 1'b0;
        exp_q = '0; exp_r = '0; exp_z = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    end

    always @(posedge clk) begin
        ec = ec + 1;
        if (rst) begin
            exp_q = '0; exp_r = '0; exp_z = 1'b0;
            done_at = -10; busy_lo = -10; busy_hi = -10;
            ready = ec + 1;
            model_en = 1'b1;
        end else begin
            if (ec >= ready && start) begin
                if (divisor == 0) begin
                    pq = 4'hF; pr = dividend; pz = 1'b1;
                    done_at = ec; ready = ec + 2;
                    busy_lo = -10; busy_hi = -10;
                end else begin
                    pq = W'(int'(dividend) / int'(divisor));
                    pr = W'(int'(dividend) % int'(divisor));
                    pz = 1'b0; exp_z = 1'b0;
                    busy_lo = ec; busy_hi = ec + W - 1;
                    done_at = ec + W; ready = ec + W + 2;
                end
            end
            if (ec == done_at) begin
                exp_q = pq; exp_r = pr; exp_z = pz;
            end
        end
        exp_busy = (ec >= busy_lo) && (ec <= busy_hi);
        exp_done = !rst && (ec == done_at);
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_en) begin
            chk("cyc_quotient", int'(quotient), int'(exp_q));
            chk("cyc_remainder", int'(remainder), int'(exp_r));
            chk("cyc_busy", int'(busy), int'(exp_busy));
            chk("cyc_done", int'(done), int'(exp_done));
            chk("cyc_div_by_zero", int'(div_by_zero), int'(exp_z));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] d,
                          input int eq, input int er, input int ez, input int elat);
        int lat = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        int rq = 0;
        int rr = 0;
        @(posedge clk); #1;
        start = 1'b1; dividend = a; divisor = d;
        @(posedge clk); #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1; rq = int'(quotient); rr = int'(remainder);
            end else begin
                lat++;
            end
        end
        chk("done_seen", int'(seen), 1);
        if (seen) begin
            chk("latency", lat, elat);
            chk("busy_cycles", bcnt, (d == 0) ? 0 : W);
            chk("quotient", rq, eq);
            chk("remainder", rr, er);
            chk("div_by_zero", int'(div_by_zero), ez);
            if (a < 4 && d < 4 && d != 0) chk("mult_identity", rq * int'(d) + rr, int'(a));
        end
    endtask

    initial begin
        int dcnt;
        int cq;
        int cr;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        run_op(4'd13, 4'd3, 4, 1, 0, 4);
        run_op(4'd15, 4'd1, 15, 0, 0, 4);
        run_op(4'd5, 4'd7, 0, 5, 0, 4);
        run_op(4'd0, 4'd5, 0, 0, 0, 4);
        run_op(4'd15, 4'd15, 1, 0, 0, 4);
        run_op(4'd9, 4'd0, 15, 9, 1, 0);
        run_op(4'd8, 4'd2, 4, 0, 0, 4);

        // Re-pulsed start during calculation must be ignored.
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd14; divisor = 4'd4;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1; dividend = 4'd3; divisor = 4'd1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        dcnt = 0; cq = -1; cr = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin dcnt++; cq = int'(quotient); cr = int'(remainder); end
        end
        chk("repulse_done_count", dcnt, 1);
        chk("repulse_quotient", cq, 3);
        chk("repulse_remainder", cr, 2);

        // Reset mid-division discards the result.
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_busy", int'(busy), 0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        run_op(4'd12, 4'd5, 2, 2, 0, 4);

        // Exhaustive sweep at minimum spacing.
        for (int a = 0; a < 16; a++) begin
            for (int d = 0; d < 16; d++) begin
                if (d == 0) run_op(W'(a), W'(d), 15, a, 1, 0);
                else        run_op(W'(a), W'(d), a / d, a % d, 0, 4);
            end
        end

        // Random traffic: starts at any time, occasional reset, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start    = ($urandom_range(0, 2) == 0);
            dividend = W'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
